// File: rtl/sort4_engine.sv
// Four-word buffer sorted in place by odd-even transposition, then drained in order.
// Define SORT4_DESCEND_EN for descending output (maximum first).

module sort4_cas #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic             swap
);
`ifdef SORT4_DESCEND_EN
  assign swap = $signed(lo) < $signed(hi);
`else
  assign swap = $signed(lo) > $signed(hi);
`endif
endmodule

module sort4_engine #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);
  localparam logic [1:0] LOAD  = 2'd0;
  localparam logic [1:0] SORT  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]            state;
  logic [3:0][WIDTH-1:0] bank;
  logic [1:0]            wr_idx, rd_idx, pass;
  logic [2:0]            swap;

  // swap[g] compares neighbours (g, g+1); even passes use 0 and 2, odd passes use 1
  for (genvar g = 0; g < 3; g++) begin : g_cas
    sort4_cas #(.WIDTH(WIDTH)) u_cas (
      .lo   (bank[g]),
      .hi   (bank[g+1]),
      .swap (swap[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= LOAD;
      bank   <= '0;
      wr_idx <= 2'd0;
      rd_idx <= 2'd0;
      pass   <= 2'd0;
    end else begin
      case (state)
        LOAD: if (in_valid) begin
          bank[wr_idx] <= in_data;
          wr_idx       <= wr_idx + 2'd1;
          if (wr_idx == 2'd3) begin
            state <= SORT;
            pass  <= 2'd0;
          end
        end
        SORT: begin
          if (!pass[0]) begin
            if (swap[0]) begin
              bank[0] <= bank[1];
              bank[1] <= bank[0];
            end
            if (swap[2]) begin
              bank[2] <= bank[3];
              bank[3] <= bank[2];
            end
          end else if (swap[1]) begin
            bank[1] <= bank[2];
            bank[2] <= bank[1];
          end
          pass <= pass + 2'd1;
          if (pass == 2'd3) begin
            state  <= DRAIN;
            rd_idx <= 2'd0;
          end
        end
        DRAIN: if (out_ready) begin
          rd_idx <= rd_idx + 2'd1;
          if (rd_idx == 2'd3) state <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == DRAIN);
  assign out_data  = out_valid ? bank[rd_idx] : '0;
  assign busy      = (state != LOAD) || (wr_idx != 2'd0);

endmodule

// File: tb/tb_sort4_engine.sv
// Directed bench for sort4_engine: ordering, latency, backpressure, ignored input, reset.
// Expected order flips when SORT4_DESCEND_EN is defined.

module tb_sort4_engine;
  localparam int WIDTH = 32;
  typedef logic [WIDTH-1:0] blk_t [4];

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [WIDTH-1:0] in_data, out_data;
  int               n_pass = 0, n_total = 0;

  sort4_engine #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // expected values are written ascending; the descending build reverses them
  function automatic blk_t ord(input blk_t asc);
    blk_t r;
`ifdef SORT4_DESCEND_EN
    for (int i = 0; i < 4; i++) r[i] = asc[3-i];
`else
    r = asc;
`endif
    return r;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  1);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_data"},  out_data,       0);
    chk({tag, "_busy"},      32'(busy),      0);
  endtask

  task automatic load_block(input blk_t w);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = w[i];
      chk("load_in_ready", 32'(in_ready), 1);
      step();
      if (i == 0) chk("load_busy", 32'(busy), 1);
    end
    in_valid = 1'b0;
  endtask

  // entered in cycle c+1; out_valid should appear in cycle c+5
  task automatic wait_out();
    int lat;
    lat = 1;
    while (!out_valid && lat < 20) begin
      chk("sort_in_ready", 32'(in_ready), 0);
      step();
      lat++;
    end
    chk("latency", lat, 5);
  endtask

  task automatic drain(input blk_t exp);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 32'(out_valid), 1);
      chk("drain_data", out_data, exp[i]);
      chk("drain_in_ready", 32'(in_ready), 0);
      if (i == 3) in_valid = 1'b0;
      step();
    end
    chk("post_drain_valid", 32'(out_valid), 0);
    chk("post_drain_in_ready", 32'(in_ready), 1);
    chk("post_drain_busy", 32'(busy), 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    blk_t exp;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    step();
    chk_idle("reset");
    rst = 1'b0;

    // basic sort
    load_block('{10, 5, -3, 7});
    wait_out();
    drain(ord('{-3, 5, 7, 10}));

    // duplicates
    load_block('{7, 7, -1, 7});
    wait_out();
    drain(ord('{-1, 7, 7, 7}));

    // signed extremes, reverse order
    load_block('{32'h7fffffff, 32'h0, 32'hffffffff, 32'h80000000});
    wait_out();
    drain(ord('{32'h80000000, 32'hffffffff, 32'h0, 32'h7fffffff}));

    // already sorted
    load_block('{1, 2, 3, 4});
    wait_out();
    drain(ord('{1, 2, 3, 4}));

    // backpressure after the first transfer
    exp = ord('{-3, 5, 7, 10});
    load_block('{10, 5, -3, 7});
    wait_out();
    out_ready = 1'b1;
    chk("bp_first", out_data, exp[0]);
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_data", out_data, exp[1]);
      chk("bp_hold_valid", 32'(out_valid), 1);
      step();
    end
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      chk("bp_resume", out_data, exp[i]);
      step();
    end
    chk("bp_done_valid", 32'(out_valid), 0);

    // in_valid held with 99 through SORT and DRAIN
    load_block('{8, -8, 0, 3});
    in_valid = 1'b1;
    in_data  = 99;
    wait_out();
    drain(ord('{-8, 0, 3, 8}));
    load_block('{2, 9, 4, 1});
    wait_out();
    drain(ord('{1, 2, 4, 9}));

    // reset during SORT pass 2
    load_block('{50, 40, 30, 20});
    step();
    step();
    pulse_reset();
    chk_idle("rst_sort");
    load_block('{4, 3, 2, 1});
    wait_out();
    drain(ord('{1, 2, 3, 4}));

    // reset after the second DRAIN transfer
    load_block('{60, 70, 80, 90});
    wait_out();
    out_ready = 1'b1;
    step();
    step();
    pulse_reset();
    chk_idle("rst_drain");
    load_block('{4, 3, 2, 1});
    wait_out();
    drain(ord('{1, 2, 3, 4}));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end
endmodule
